// File: rtl/mem_link_pkg.sv
// Shared encodings and message layout for the CPU <-> UART memory link.
package mem_link_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MSG_W  = 72;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned MASK_W = 4;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    localparam logic [LEN_W-1:0] LEN_RD_REQ  = 5'd5;
    localparam logic [LEN_W-1:0] LEN_WR_REQ  = 5'd9;
    localparam logic [LEN_W-1:0] LEN_RD_RESP = 5'd4;

    // Field offsets: a read request carries only the address at bit 0,
    // a write request carries data, then address, then byte mask.
    localparam int unsigned RD_ADDR_LO = 0;
    localparam int unsigned WDATA_LO   = 0;
    localparam int unsigned ADDR_LO    = 32;
    localparam int unsigned MASK_LO    = 64;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} bridge_state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       is_unsigned;
    } req_attr_t;

    function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
        logic [MASK_W-1:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// CPU request/response and channel message signals of the memory bridge.
interface uart_mem_bridge_if;
    import mem_link_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                tx_flag;
    logic [LEN_W-1:0]    tx_len;
    logic [MSG_W-1:0]    tx_data;
    logic                tx_ready;
    logic                rx_flag;
    logic [LEN_W-1:0]    rx_len;
    logic [MSG_W-1:0]    rx_data;
    logic                rx_valid;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  tx_ready, rx_len, rx_data, rx_valid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output tx_flag, tx_len, tx_data, rx_flag
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output tx_ready, rx_len, rx_data, rx_valid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  tx_flag, tx_len, tx_data, rx_flag
    );

endinterface

// File: rtl/mem_load_extend.sv
// Size selection and zero/sign extension of a 32-bit load reply.
module mem_load_extend
    import mem_link_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data_c
);

    always_comb begin
        data_c = raw;
        case (size)
            SZ_BYTE: data_c = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: data_c = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: data_c = raw;
        endcase
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// Turns one CPU load/store at a time into a channel-0 message and, for loads,
// waits for the 4-byte reply and returns extended read data.
module uart_mem_bridge
    import mem_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned CNT_W          = 21
) (
    input  logic             CLK,
    input  logic             RST,
    uart_mem_bridge_if.slave bus
);

    bridge_state_t     state;
    req_attr_t         attr;
    logic              err_q;
    logic [DATA_W-1:0] raw_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] ext_c;
    logic [MSG_W-1:0]  msg_c;
    logic [LEN_W-1:0]  len_c;
    logic              rx_take_c;
    logic              unused_c;

    // A reply is taken only if it is not already being popped this cycle.
    assign rx_take_c = bus.rx_valid && !bus.rx_flag;
    assign unused_c  = ^bus.rx_data[MSG_W-1:DATA_W];

    mem_load_extend u_ext (
        .raw         (raw_q),
        .size        (attr.size),
        .is_unsigned (attr.is_unsigned),
        .data_c      (ext_c)
    );

    always_comb begin
        msg_c = '0;
        len_c = LEN_RD_REQ;
        if (bus.req_we) begin
            len_c                      = LEN_WR_REQ;
            msg_c[WDATA_LO +: DATA_W]  = bus.req_wdata;
            msg_c[ADDR_LO +: ADDR_W]   = bus.req_addr;
            msg_c[MASK_LO +: MASK_W]   = size_mask(bus.req_size);
        end else begin
            msg_c[RD_ADDR_LO +: ADDR_W] = bus.req_addr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            attr           <= '0;
            err_q          <= 1'b0;
            raw_q          <= '0;
            cnt            <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.tx_flag    <= 1'b0;
            bus.tx_len     <= '0;
            bus.tx_data    <= '0;
            bus.rx_flag    <= 1'b0;
        end else begin
            bus.tx_flag    <= 1'b0;
            bus.rx_flag    <= 1'b0;
            bus.resp_valid <= 1'b0;
            // Stray replies are popped in every state but WAIT_RESP.
            if (state != WAIT_RESP && rx_take_c) begin
                bus.rx_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.req_ready && bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        attr  <= '{we: bus.req_we, size: bus.req_size,
                                   is_unsigned: bus.req_unsigned};
                        raw_q <= '0;
                        if (bus.req_size == SZ_ILLEGAL) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q       <= 1'b0;
                            bus.tx_len  <= len_c;
                            bus.tx_data <= msg_c;
                            state       <= SEND;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        bus.tx_flag <= 1'b1;
                        cnt         <= '0;
                        state       <= attr.we ? DONE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rx_take_c) begin
                        bus.rx_flag <= 1'b1;
                        state       <= DONE;
                        if (bus.rx_len == LEN_RD_RESP) begin
                            raw_q <= bus.rx_data[DATA_W-1:0];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= err_q;
                    bus.resp_rdata <= err_q ? '0 : ext_c;
                    bus.req_ready  <= 1'b1;
                    cnt            <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized self-checking bench for uart_mem_bridge with a channel/memory model.
module tb_uart_mem_bridge;
    import mem_link_pkg::*;

    localparam int unsigned TMO = 100;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_fail = 0;

    int   steps = 0;
    int   acc_at, tx_at, resp_at;
    int   tx_cnt, rx_cnt, resp_cnt;
    logic [4:0]  tx_len_o;
    logic [71:0] tx_data_o;
    logic [31:0] rdata_o;
    logic err_o, rdy_at_resp, flag_bad;
    logic pop_pend = 1'b0;

    always #5 CLK = ~CLK;

    uart_mem_bridge_if bus ();

    uart_mem_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(21)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference: take the low 1/2/4 bytes of the reply and extend arithmetically.
    function automatic logic [31:0] exp_load(input int size, input logic uns, input logic [31:0] raw);
        longint v;
        int bits;
        bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
        v = longint'(raw) % (longint'(1) << bits);
        if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_mask(input int size);
        return 4'((1 << (1 << size)) - 1);
    endfunction

    task automatic clear_obs();
        tx_cnt = 0; rx_cnt = 0; resp_cnt = 0;
        tx_at = -1000; resp_at = -1000; acc_at = -1000;
        tx_len_o = '0; tx_data_o = '0; rdata_o = '0;
        err_o = 1'b0; rdy_at_resp = 1'b0; flag_bad = 1'b0;
    endtask

    // One clock; observe outputs just after the edge and act as the channel.
    task automatic step();
        @(posedge CLK);
        #1;
        steps++;
        if (pop_pend) bus.rx_valid = 1'b0;
        pop_pend = bus.rx_flag;
        if (bus.tx_flag === 1'b1) begin
            tx_cnt++; tx_len_o = bus.tx_len; tx_data_o = bus.tx_data; tx_at = steps;
            if (bus.tx_ready !== 1'b1) flag_bad = 1'b1;
        end
        if (bus.rx_flag === 1'b1) begin
            rx_cnt++;
            if (bus.rx_valid !== 1'b1) flag_bad = 1'b1;
        end
        if (bus.resp_valid === 1'b1) begin
            resp_cnt++; rdata_o = bus.resp_rdata; err_o = bus.resp_err;
            resp_at = steps; rdy_at_resp = bus.req_ready;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int txd, input int rpd, input logic reply,
                          input logic [4:0] rlen, input logic [31:0] rdat);
        int   wait_n;
        logic replied;
        clear_obs();
        replied = 1'b0;
        wait_n = 0;
        while (bus.req_ready !== 1'b1 && wait_n < 20) begin step(); wait_n++; end
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        bus.tx_ready = (txd == 0);
        step();
        acc_at = steps;
        bus.req_valid = 1'b0;
        for (int i = 0; i < int'(TMO) + 100; i++) begin
            bus.tx_ready = ((steps - acc_at) >= txd);
            if (reply && !replied && tx_cnt > 0 && steps == tx_at + rpd) begin
                bus.rx_valid = 1'b1;
                bus.rx_len = rlen;
                bus.rx_data = {8'($urandom), 32'($urandom), rdat};
                replied = 1'b1;
            end
            step();
            if (resp_cnt > 0 && steps >= resp_at + 2) break;
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_len = '0; bus.rx_data = '0;
        #12;
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.tx_flag, bus.rx_flag} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.tx_flag, bus.rx_flag});
        end
        n_cmp++;
        if ({bus.resp_rdata, bus.tx_len, bus.tx_data} !== 109'b0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h tx_len=%h tx_data=%h want all 0",
                     bus.resp_rdata, bus.tx_len, bus.tx_data);
        end
        @(negedge CLK);
        RST = 1'b0;
        step(); step();
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_word_load();
        do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 0, 50, 1'b1, LEN_RD_RESP, 32'hDEADBEEF);
        n_cmp++;
        if (tx_cnt !== 1 || tx_len_o !== 5'd5 || tx_data_o !== 72'h100) begin
            n_fail++; $display("FAIL wl_msg: cnt=%0d len=%0d data=%h want 1/5/%h", tx_cnt, tx_len_o, tx_data_o, 72'h100);
        end
        n_cmp++;
        if (resp_cnt !== 1 || rdata_o !== 32'hDEADBEEF || err_o !== 1'b0) begin
            n_fail++; $display("FAIL wl_resp: cnt=%0d rdata=%h err=%b want 1/deadbeef/0", resp_cnt, rdata_o, err_o);
        end
        n_cmp++;
        if (rx_cnt !== 1 || flag_bad !== 1'b0) begin
            n_fail++; $display("FAIL wl_pop: rx_flags=%0d bad=%b want 1/0", rx_cnt, flag_bad);
        end
        n_cmp++;
        if (resp_at - tx_at !== 52 || rdy_at_resp !== 1'b1) begin
            n_fail++; $display("FAIL wl_latency: got %0d ready=%b want 52/1", resp_at - tx_at, rdy_at_resp);
        end
    endtask

    task automatic test_load_extend();
        logic [1:0] sz;
        logic un;
        logic [31:0] ad, rd, want;
        int txd, rpd;
        for (int i = 0; i < 27; i++) begin
            txd = 0; rpd = 3;
            if (i == 0) begin sz = SZ_BYTE; un = 1'b0; ad = 32'h3; rd = 32'hF0; end
            else if (i == 1) begin sz = SZ_BYTE; un = 1'b1; ad = 32'h3; rd = 32'hF0; end
            else if (i == 2) begin sz = SZ_HALF; un = 1'b1; ad = 32'h40; rd = 32'h8001; end
            else begin
                sz = 2'($urandom_range(0, 2)); un = 1'($urandom);
                ad = $urandom; rd = $urandom;
                txd = $urandom_range(0, 3); rpd = $urandom_range(0, 20);
            end
            want = exp_load(int'(sz), un, rd);
            do_req(1'b0, sz, un, ad, $urandom, txd, rpd, 1'b1, LEN_RD_RESP, rd);
            n_cmp++;
            if (resp_cnt !== 1 || rdata_o !== want || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ld_ext[%0d] sz=%0d u=%b raw=%h: cnt=%0d rdata=%h err=%b want 1/%h/0",
                         i, sz, un, rd, resp_cnt, rdata_o, err_o, want);
            end
            n_cmp++;
            if (tx_cnt !== 1 || tx_len_o !== LEN_RD_REQ || tx_data_o !== {40'b0, ad} || rx_cnt !== 1) begin
                n_fail++;
                $display("FAIL ld_msg[%0d]: tx=%0d len=%0d data=%h pops=%0d want 1/5/%h/1",
                         i, tx_cnt, tx_len_o, tx_data_o, rx_cnt, {40'b0, ad});
            end
            n_cmp++;
            if (tx_at - acc_at !== txd + 1 || resp_at - tx_at !== rpd + 2 || flag_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL ld_timing[%0d]: send=%0d resp=%0d bad=%b want %0d/%0d/0",
                         i, tx_at - acc_at, resp_at - tx_at, flag_bad, txd + 1, rpd + 2);
            end
        end
    endtask

    task automatic test_store();
        logic [1:0] sz;
        logic [31:0] ad, wd;
        int txd;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) begin sz = SZ_HALF; ad = 32'h202; wd = 32'h1234ABCD; txd = 7; end
            else begin
                sz = 2'($urandom_range(0, 2)); ad = $urandom; wd = $urandom;
                txd = $urandom_range(0, 5);
            end
            do_req(1'b1, sz, 1'($urandom), ad, wd, txd, 0, 1'b0, 5'd0, 32'h0);
            n_cmp++;
            if (tx_cnt !== 1 || tx_len_o !== LEN_WR_REQ || tx_data_o !== {4'h0, exp_mask(int'(sz)), ad, wd}) begin
                n_fail++;
                $display("FAIL st_msg[%0d]: tx=%0d len=%0d data=%h want 1/9/%h",
                         i, tx_cnt, tx_len_o, tx_data_o, {4'h0, exp_mask(int'(sz)), ad, wd});
            end
            n_cmp++;
            if (tx_at - acc_at !== txd + 1 || resp_at - tx_at !== 1 || flag_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL st_timing[%0d]: send=%0d resp=%0d bad=%b want %0d/1/0",
                         i, tx_at - acc_at, resp_at - tx_at, flag_bad, txd + 1);
            end
            n_cmp++;
            if (resp_cnt !== 1 || rdata_o !== 32'h0 || err_o !== 1'b0 || rx_cnt !== 0) begin
                n_fail++;
                $display("FAIL st_resp[%0d]: cnt=%0d rdata=%h err=%b pops=%0d want 1/0/0/0",
                         i, resp_cnt, rdata_o, err_o, rx_cnt);
            end
        end
    endtask

    task automatic test_errors();
        do_req(1'($urandom), SZ_ILLEGAL, 1'b0, $urandom, $urandom, 0, 0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (tx_cnt !== 0 || resp_cnt !== 1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL size3: tx=%0d resp=%0d err=%b rdata=%h want 0/1/1/0", tx_cnt, resp_cnt, err_o, rdata_o);
        end
        n_cmp++;
        if (resp_at - acc_at !== 1) begin
            n_fail++; $display("FAIL size3_latency: got %0d want 1", resp_at - acc_at);
        end
        do_req(1'b0, SZ_WORD, 1'b0, $urandom, 32'h0, 0, 4, 1'b1, 5'd9, $urandom);
        n_cmp++;
        if (rx_cnt !== 1 || resp_cnt !== 1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bad_len: pops=%0d resp=%0d err=%b rdata=%h want 1/1/1/0", rx_cnt, resp_cnt, err_o, rdata_o);
        end
    endtask

    task automatic test_timeout();
        logic rdy_low;
        do_req(1'b0, SZ_WORD, 1'b0, $urandom, 32'h0, 0, 0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (resp_cnt !== 1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL tmo_resp: cnt=%0d err=%b rdata=%h want 1/1/0", resp_cnt, err_o, rdata_o);
        end
        n_cmp++;
        if (resp_at - tx_at !== int'(TMO) + 1) begin
            n_fail++; $display("FAIL tmo_latency: got %0d want %0d", resp_at - tx_at, TMO + 1);
        end
        clear_obs();
        rdy_low = 1'b0;
        bus.rx_valid = 1'b1; bus.rx_len = LEN_RD_RESP; bus.rx_data = {40'b0, 32'($urandom)};
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.req_ready !== 1'b1) rdy_low = 1'b1;
        end
        n_cmp++;
        if (rx_cnt !== 1 || resp_cnt !== 0 || bus.rx_valid !== 1'b0 || rdy_low !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: pops=%0d resp=%0d pending=%b ready_dropped=%b want 1/0/0/0",
                     rx_cnt, resp_cnt, bus.rx_valid, rdy_low);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        clear_obs();
        bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
        bus.req_addr = $urandom; bus.req_valid = 1'b1; bus.tx_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.tx_flag, bus.rx_flag} !== 5'b0 ||
            {bus.resp_rdata, bus.tx_len, bus.tx_data} !== 109'b0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b tx_len=%h tx_data=%h want 0/0/0",
                     bus.req_ready, bus.tx_len, bus.tx_data);
        end
        step(); step();
        RST = 1'b0;
        clear_obs();
        bus.rx_valid = 1'b1; bus.rx_len = LEN_RD_RESP; bus.rx_data = {40'b0, 32'($urandom)};
        for (int i = 0; i < 8; i++) step();
        n_cmp++;
        if (rx_cnt !== 1 || resp_cnt !== 0 || bus.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_reply: pops=%0d resp=%0d pending=%b want 1/0/0", rx_cnt, resp_cnt, bus.rx_valid);
        end
        rd = $urandom;
        do_req(1'b0, SZ_WORD, 1'b1, $urandom, 32'h0, 1, 5, 1'b1, LEN_RD_RESP, rd);
        n_cmp++;
        if (resp_cnt !== 1 || rdata_o !== rd || err_o !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_load: cnt=%0d rdata=%h err=%b want 1/%h/0", resp_cnt, rdata_o, err_o, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic we, un;
        logic [1:0] sz;
        logic [31:0] rd, want;
        for (int i = 0; i < 10; i++) begin
            we = 1'($urandom); un = 1'($urandom); sz = 2'($urandom_range(0, 2)); rd = $urandom;
            want = we ? 32'h0 : exp_load(int'(sz), un, rd);
            do_req(we, sz, un, $urandom, $urandom, 0, 0, !we, LEN_RD_RESP, rd);
            n_cmp++;
            if (resp_cnt !== 1 || rdata_o !== want || err_o !== 1'b0 || rdy_at_resp !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d] we=%b: cnt=%0d rdata=%h err=%b ready=%b want 1/%h/0/1",
                         i, we, resp_cnt, rdata_o, err_o, rdy_at_resp, want);
            end
            n_cmp++;
            if (resp_at - acc_at !== (we ? 2 : 3)) begin
                n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, resp_at - acc_at, we ? 2 : 3);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_load();
        test_load_extend();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
